vme_system_controller: RTL and testbench



---
 rtl/vme_system_controller.sv | 179 +++++++++++++++++
 tb/tb_vme_system_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vme_system_controller.sv
// Slot-1 VME system controller: four-level fixed-priority bus arbiter with
// daisy-chain grant drive, plus a data-transfer bus timer that raises BERR.
module vme_system_controller #(
    parameter int unsigned BUS_TIMEOUT = 800,
    parameter int unsigned ARB_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] vme_bus_request,
    input  logic       vme_bbsy,
    input  logic       vme_as,
    input  logic [1:0] vme_ds,
    input  logic       vme_dtack,
    input  logic       vme_berr_in,
    output logic [3:0] vme_bus_grant_out,
    output logic       vme_berr,
    output logic [7:0] timeout_count,
    output logic       status_led
);

    localparam int unsigned BW = $clog2(BUS_TIMEOUT + 1);
    localparam int unsigned AW = $clog2(ARB_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    // Bus inputs packed as {berr_in, dtack, ds[1:0], as, bbsy, br[3:0]}
    logic [9:0] sync1, sync2;

    logic [3:0] br_s;
    logic       bbsy_s, as_s, dtack_s, berr_in_s, bus_busy, ds_idle;
    logic [1:0] ds_s;

    state_t      state, state_next;
    logic [1:0]  level, level_next;
    logic [AW-1:0] arb_cnt, arb_next;
    logic [3:0]  bg_q, bg_next;

    logic [BW-1:0] tmr_cnt, tmr_next;
    logic          berr_q, berr_next;
    logic [7:0]    tc_q, tc_next;

    assign br_s      = sync2[3:0];
    assign bbsy_s    = sync2[4];
    assign as_s      = sync2[5];
    assign ds_s      = sync2[7:6];
    assign dtack_s   = sync2[8];
    assign berr_in_s = sync2[9];
    assign bus_busy  = !as_s || !bbsy_s;
    assign ds_idle   = &ds_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {vme_berr_in, vme_dtack, vme_ds, vme_as, vme_bbsy, vme_bus_request};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            level   <= '0;
            arb_cnt <= '0;
            bg_q    <= '1;
        end else begin
            state   <= state_next;
            level   <= level_next;
            arb_cnt <= arb_next;
            bg_q    <= bg_next;
        end
    end

    always_comb begin
        state_next = state;
        level_next = level;
        arb_next   = arb_cnt;
        bg_next    = bg_q;
        if (!enable) begin
            state_next = ST_IDLE;
            arb_next   = '0;
            bg_next    = '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    bg_next = '1;
                    if (br_s != 4'hF && !bus_busy) begin
                        if (!br_s[3])      level_next = 2'd3;
                        else if (!br_s[2]) level_next = 2'd2;
                        else if (!br_s[1]) level_next = 2'd1;
                        else               level_next = 2'd0;
                        bg_next    = ~(4'b0001 << level_next);
                        arb_next   = '0;
                        state_next = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus_busy) begin
                        state_next = ST_OWNED;
                    end else if (br_s[level]) begin
                        state_next = ST_RELEASE;
                        bg_next    = '1;
                    end else begin
                        // Counter stops at the limit, which also withdraws the grant
                        arb_next = arb_cnt + 1'b1;
                        if (arb_next == AW'(ARB_TIMEOUT)) begin
                            state_next = ST_RELEASE;
                            bg_next    = '1;
                        end
                    end
                end
                ST_OWNED: begin
                    if (br_s[level]) begin
                        state_next = ST_RELEASE;
                        bg_next    = '1;
                    end
                end
                default: begin
                    bg_next = '1;
                    if (!bus_busy) state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr_cnt <= '0;
            berr_q  <= 1'b1;
            tc_q    <= '0;
        end else begin
            tmr_cnt <= tmr_next;
            berr_q  <= berr_next;
            tc_q    <= tc_next;
        end
    end

    always_comb begin
        tmr_next  = tmr_cnt;
        berr_next = berr_q;
        tc_next   = tc_q;
        if (!enable) begin
            tmr_next  = '0;
            berr_next = 1'b1;
        end else if (!berr_q) begin
            if (ds_idle) begin
                berr_next = 1'b1;
                tmr_next  = '0;
            end
        end else if (ds_idle || !dtack_s) begin
            tmr_next = '0;
        end else if (berr_in_s) begin
            if (tmr_cnt == BW'(BUS_TIMEOUT - 1)) begin
                tmr_next  = BW'(BUS_TIMEOUT);
                berr_next = 1'b0;
                if (tc_q != 8'hFF) tc_next = tc_q + 8'd1;
            end else begin
                tmr_next = tmr_cnt + 1'b1;
            end
        end
    end

    assign vme_bus_grant_out = bg_q;
    assign vme_berr          = berr_q;
    assign timeout_count     = tc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) status_led <= 1'b0;
        else        status_led <= (bg_next != 4'hF);
    end

endmodule

// File: tb/tb_vme_system_controller.sv
// Directed-vector bench for vme_system_controller: arbitration, grant timeout,
// bus timer, enable, async reset, plus a short-timeout instance for saturation.
module tb_vme_system_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] br;
    logic       bbsy, as_n, dtack, berr_in;
    logic [1:0] ds;
    logic [3:0] bg;
    logic       berr;
    logic [7:0] tcount;
    logic       led;

    logic [1:0] ds_f;
    logic [3:0] bg_f;
    logic       berr_f;
    logic [7:0] tcount_f;
    logic       led_f;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    vme_system_controller #(.BUS_TIMEOUT(800), .ARB_TIMEOUT(64)) u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .vme_bus_request(br), .vme_bbsy(bbsy), .vme_as(as_n), .vme_ds(ds),
        .vme_dtack(dtack), .vme_berr_in(berr_in),
        .vme_bus_grant_out(bg), .vme_berr(berr), .timeout_count(tcount),
        .status_led(led)
    );

    vme_system_controller #(.BUS_TIMEOUT(4), .ARB_TIMEOUT(4)) u_fast (
        .clock(clock), .reset(reset), .enable(1'b1),
        .vme_bus_request(4'hF), .vme_bbsy(1'b1), .vme_as(1'b1), .vme_ds(ds_f),
        .vme_dtack(1'b1), .vme_berr_in(1'b1),
        .vme_bus_grant_out(bg_f), .vme_berr(berr_f), .timeout_count(tcount_f),
        .status_led(led_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; br = 4'hF; bbsy = 1'b1; as_n = 1'b1;
        ds = 2'b11; dtack = 1'b1; berr_in = 1'b1; ds_f = 2'b11;
        tick(3);
        check("rst_bg", bg, 4'hF);
        check("rst_berr", berr, 1);
        check("rst_tc", tcount, 0);
        check("rst_led", led, 0);
        reset = 1'b1;
        tick(3);

        // Single request, owned tenure, release
        br = 4'b0111;
        tick(2); check("bg3_early", bg, 4'hF);
        tick(1); check("bg3_grant", bg, 4'b0111);
        check("led_on", led, 1);
        as_n = 1'b0;
        tick(3);
        br = 4'hF;
        tick(2); check("bg3_held", bg, 4'b0111);
        tick(1); check("bg3_release", bg, 4'hF);
        check("led_off", led, 0);
        tick(5); check("release_busy", bg, 4'hF);
        as_n = 1'b1;
        tick(4);

        // Priority: BR2 and BR1 together
        br = 4'b1001;
        tick(3); check("prio_bg2", bg, 4'b1011);
        br = 4'b1101;
        tick(3); check("prio_bg2_rel", bg, 4'hF);
        tick(1); check("prio_gap", bg, 4'hF);
        tick(1); check("prio_bg1", bg, 4'b1101);
        br = 4'hF;
        tick(3); check("prio_bg1_rel", bg, 4'hF);
        tick(3);

        // Unclaimed grant withdrawn then re-granted
        br = 4'b1110;
        tick(3); check("bg0_grant", bg, 4'b1110);
        tick(63); check("bg0_before_limit", bg, 4'b1110);
        tick(1); check("bg0_withdrawn", bg, 4'hF);
        tick(1); check("bg0_idle", bg, 4'hF);
        tick(1); check("bg0_regrant", bg, 4'b1110);
        br = 4'hF;
        tick(3); check("bg0_rel", bg, 4'hF);
        tick(3);

        // Bus timeout
        ds = 2'b00;
        tick(801); check("berr_before", berr, 1);
        tick(1); check("berr_assert", berr, 0);
        check("tc_one", tcount, 1);
        tick(20); check("berr_hold", berr, 0);
        check("tc_once", tcount, 1);
        ds = 2'b11;
        tick(2); check("berr_ds_hold", berr, 0);
        tick(1); check("berr_release", berr, 1);
        tick(3);

        // Normal cycle: DTACK clears the timer; count restarts after DTACK releases
        ds = 2'b00;
        tick(20);
        dtack = 1'b0;
        tick(10); check("normal_no_berr", berr, 1);
        check("normal_tc", tcount, 1);
        dtack = 1'b1;
        tick(801); check("restart_before", berr, 1);
        tick(1); check("restart_assert", berr, 0);
        check("tc_two", tcount, 2);
        ds = 2'b11;
        tick(4);

        // DTACK on the limit edge wins
        ds = 2'b00;
        tick(799);
        dtack = 1'b0;
        tick(3); check("race_no_berr", berr, 1);
        tick(5); check("race_tc", tcount, 2);
        ds = 2'b11; dtack = 1'b1;
        tick(4);

        // Enable low withdraws the grant on the next edge
        br = 4'b0111;
        tick(3); check("en_grant", bg, 4'b0111);
        enable = 1'b0;
        tick(1); check("en_off_bg", bg, 4'hF);
        check("en_off_led", led, 0);
        tick(2);
        enable = 1'b1;
        tick(1); check("en_regrant", bg, 4'b0111);
        br = 4'hF;
        tick(5);

        // Async reset mid-tenure with timer running
        br = 4'b1011;
        tick(3); check("ar_grant", bg, 4'b1011);
        ds = 2'b00;
        tick(503);
        #2 reset = 1'b0;
        #1 check("ar_bg", bg, 4'hF);
        check("ar_berr", berr, 1);
        check("ar_tc", tcount, 0);
        ds = 2'b11;
        reset = 1'b1;
        tick(2); check("ar_bg2_early", bg, 4'hF);
        tick(1); check("ar_bg2_grant", bg, 4'b1011);
        br = 4'hF;
        tick(4);

        // Short-timeout instance: timing and saturation
        ds_f = 2'b00;
        tick(5); check("fast_before", berr_f, 1);
        tick(1); check("fast_assert", berr_f, 0);
        ds_f = 2'b11;
        tick(3); check("fast_release", berr_f, 1);
        for (int i = 1; i < 255; i++) begin
            ds_f = 2'b00;
            tick(6);
            ds_f = 2'b11;
            tick(3);
        end
        check("fast_tc_255", tcount_f, 255);
        for (int i = 0; i < 4; i++) begin
            ds_f = 2'b00;
            tick(6);
            ds_f = 2'b11;
            tick(3);
        end
        check("fast_tc_sat", tcount_f, 255);
        check("fast_bg_idle", bg_f, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
